// File: rtl/id_exe_stage_reg_pkg.sv
// Shared types and defaults for the ID/EXE pipeline register.
package id_exe_stage_reg_pkg;

  localparam int WORD_W_DFLT     = 32;
  localparam int REG_ADDR_W_DFLT = 4;
  localparam int EXE_CMD_W_DFLT  = 4;

  typedef enum logic [EXE_CMD_W_DFLT-1:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_MVN = 4'b1001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000
  } exe_cmd_e;

  typedef struct packed {
    logic                      wb_en;
    logic                      mem_r;
    logic                      mem_w;
    logic                      b;
    logic                      s;
    logic [EXE_CMD_W_DFLT-1:0] exe_cmd;
  } ctrl_t;

  // A bubble never writes back or touches memory; branches never update
  // flags; a read+write request degrades to a plain read.
  function automatic ctrl_t sanitise_ctrl(input ctrl_t raw, input logic valid);
    ctrl_t c;
    c         = raw;
    c.wb_en   = valid & raw.wb_en;
    c.mem_r   = valid & raw.mem_r;
    c.mem_w   = valid & raw.mem_w & ~raw.mem_r;
    c.b       = valid & raw.b;
    c.s       = valid & raw.s & ~raw.b;
    return c;
  endfunction

endpackage

// File: rtl/id_exe_stage_reg_if.sv
// Decode-to-execute bus; src1/src2 exist only when FORWARDING_EN is defined.
interface id_exe_stage_reg_if
  import id_exe_stage_reg_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DFLT,
  parameter int REG_ADDR_W = REG_ADDR_W_DFLT,
  parameter int EXE_CMD_W  = EXE_CMD_W_DFLT
);
  logic                  flush;
  logic                  freeze;

  logic                  WB_EN_in, MEM_R_in, MEM_W_in, B_in, S_in;
  logic [EXE_CMD_W-1:0]  EXE_CMD_in;
  logic [WORD_W-1:0]     PC_in, Val_Rn_in, Val_Rm_in;
  logic                  imm_in;
  logic [11:0]           Shift_operand_in;
  logic [23:0]           Signed_imm_24_in;
  logic [REG_ADDR_W-1:0] Dest_in;
  logic [3:0]            SR_in;
  logic                  valid_in;

  logic                  WB_EN_out, MEM_R_out, MEM_W_out, B_out, S_out;
  logic [EXE_CMD_W-1:0]  EXE_CMD_out;
  logic [WORD_W-1:0]     PC_out, Val_Rn_out, Val_Rm_out;
  logic                  imm_out;
  logic [11:0]           Shift_operand_out;
  logic [23:0]           Signed_imm_24_out;
  logic [REG_ADDR_W-1:0] Dest_out;
  logic [3:0]            SR_out;
  logic                  valid_out;
  logic                  err_out;
`ifdef FORWARDING_EN
  logic [REG_ADDR_W-1:0] src1_in, src2_in, src1_out, src2_out;
`endif

  modport master (
    output flush, freeze,
    output WB_EN_in, MEM_R_in, MEM_W_in, B_in, S_in, EXE_CMD_in, PC_in,
           Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in, Signed_imm_24_in,
           Dest_in, SR_in, valid_in,
`ifdef FORWARDING_EN
    output src1_in, src2_in,
    input  src1_out, src2_out,
`endif
    input  WB_EN_out, MEM_R_out, MEM_W_out, B_out, S_out, EXE_CMD_out, PC_out,
           Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out,
           Signed_imm_24_out, Dest_out, SR_out, valid_out, err_out
  );

  modport slave (
    input  flush, freeze,
    input  WB_EN_in, MEM_R_in, MEM_W_in, B_in, S_in, EXE_CMD_in, PC_in,
           Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in, Signed_imm_24_in,
           Dest_in, SR_in, valid_in,
`ifdef FORWARDING_EN
    input  src1_in, src2_in,
    output src1_out, src2_out,
`endif
    output WB_EN_out, MEM_R_out, MEM_W_out, B_out, S_out, EXE_CMD_out, PC_out,
           Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out,
           Signed_imm_24_out, Dest_out, SR_out, valid_out, err_out
  );
endinterface

// File: rtl/id_exe_stage_reg_pipe_field_reg.sv
// One field group of the pipeline register: reset > clear > hold > load.
module pipe_field_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             hold,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Field storage with clear taking priority over hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (hold) begin
      q <= q;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with flush/freeze, load sanitisation and a sticky
// illegal-combination flag. Optional source-register fields: FORWARDING_EN.
module id_exe_stage_reg
  import id_exe_stage_reg_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DFLT,
  parameter int REG_ADDR_W = REG_ADDR_W_DFLT,
  parameter int EXE_CMD_W  = EXE_CMD_W_DFLT
) (
  input logic               clk,
  input logic               rst,
  id_exe_stage_reg_if.slave bus
);

  localparam int CTRL_W = 5 + EXE_CMD_W + 1;
  localparam int DATA_W = 3 * WORD_W + 1 + 12 + 24 + REG_ADDR_W;

  ctrl_t               raw_ctrl_s;
  ctrl_t               san_ctrl_s;
  ctrl_t               ctrl_out_s;
  logic [CTRL_W-1:0]   ctrl_q_s;
  logic [DATA_W-1:0]   data_d_s;
  logic [DATA_W-1:0]   data_q_s;
  logic [3:0]          sr_q_s;
  logic                illegal_s;
  logic                err_r;

  // Assemble and sanitise the incoming control bundle.
  always_comb begin
    raw_ctrl_s.wb_en   = bus.WB_EN_in;
    raw_ctrl_s.mem_r   = bus.MEM_R_in;
    raw_ctrl_s.mem_w   = bus.MEM_W_in;
    raw_ctrl_s.b       = bus.B_in;
    raw_ctrl_s.s       = bus.S_in;
    raw_ctrl_s.exe_cmd = bus.EXE_CMD_in;
    san_ctrl_s         = sanitise_ctrl(raw_ctrl_s, bus.valid_in);
  end

  assign data_d_s  = {bus.PC_in, bus.Val_Rn_in, bus.Val_Rm_in, bus.imm_in,
                      bus.Shift_operand_in, bus.Signed_imm_24_in, bus.Dest_in};
  // Only a real instruction can carry an illegal read+write request.
  assign illegal_s = bus.valid_in & bus.MEM_R_in & bus.MEM_W_in;

  pipe_field_reg #(.WIDTH(CTRL_W)) u_ctrl (
    .clk(clk), .rst(rst), .clr(bus.flush), .hold(bus.freeze),
    .d({san_ctrl_s, bus.valid_in}), .q(ctrl_q_s)
  );

  pipe_field_reg #(.WIDTH(DATA_W)) u_data (
    .clk(clk), .rst(rst), .clr(bus.flush), .hold(bus.freeze),
    .d(data_d_s), .q(data_q_s)
  );

  pipe_field_reg #(.WIDTH(4)) u_status (
    .clk(clk), .rst(rst), .clr(bus.flush), .hold(bus.freeze),
    .d(bus.SR_in), .q(sr_q_s)
  );

`ifdef FORWARDING_EN
  logic [2*REG_ADDR_W-1:0] fwd_q_s;

  pipe_field_reg #(.WIDTH(2 * REG_ADDR_W)) u_fwd (
    .clk(clk), .rst(rst), .clr(bus.flush), .hold(bus.freeze),
    .d({bus.src1_in, bus.src2_in}), .q(fwd_q_s)
  );

  assign {bus.src1_out, bus.src2_out} = fwd_q_s;
`endif

  // Sticky error flag, set only on an actual load; cleared by reset alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (!bus.flush && !bus.freeze && illegal_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign ctrl_out_s      = ctrl_q_s[CTRL_W-1:1];
  assign bus.valid_out   = ctrl_q_s[0];
  assign bus.WB_EN_out   = ctrl_out_s.wb_en;
  assign bus.MEM_R_out   = ctrl_out_s.mem_r;
  assign bus.MEM_W_out   = ctrl_out_s.mem_w;
  assign bus.B_out       = ctrl_out_s.b;
  assign bus.S_out       = ctrl_out_s.s;
  assign bus.EXE_CMD_out = ctrl_out_s.exe_cmd;
  assign {bus.PC_out, bus.Val_Rn_out, bus.Val_Rm_out, bus.imm_out,
          bus.Shift_operand_out, bus.Signed_imm_24_out, bus.Dest_out} = data_q_s;
  assign bus.SR_out      = sr_q_s;
  assign bus.err_out     = err_r;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Randomised self-checking bench for id_exe_stage_reg (FORWARDING_EN aware).
module tb_id_exe_stage_reg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  id_exe_stage_reg_if bus ();
  id_exe_stage_reg dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic wb, mr, mw, b, s;
    logic [3:0]  cmd;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [3:0]  dest, sr;
    logic        valid;
`ifdef FORWARDING_EN
    logic [3:0]  src1, src2;
`endif
  } in_t;

  typedef struct packed {
    in_t  f;
    logic err;
  } obs_t;

  obs_t exp_st;

  // Reference: what the execute stage should see after one edge.
  function automatic obs_t model(input obs_t cur, input in_t i, input bit fl, input bit fr);
    obs_t n;
    if (fl) begin
      n     = '0;
      n.err = cur.err;
    end else if (fr) begin
      n = cur;
    end else begin
      n.f    = i;
      n.f.wb = i.valid && i.wb;
      n.f.mr = i.valid && i.mr;
      n.f.mw = i.valid && i.mw && !i.mr;
      n.f.b  = i.valid && i.b;
      n.f.s  = i.valid && i.s && !i.b;
      n.err  = cur.err || (i.valid && i.mr && i.mw);
    end
    return n;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.f.wb = bus.WB_EN_out;  o.f.mr = bus.MEM_R_out; o.f.mw = bus.MEM_W_out;
    o.f.b  = bus.B_out;      o.f.s  = bus.S_out;     o.f.cmd = bus.EXE_CMD_out;
    o.f.pc = bus.PC_out;     o.f.rn = bus.Val_Rn_out; o.f.rm = bus.Val_Rm_out;
    o.f.imm = bus.imm_out;   o.f.sh = bus.Shift_operand_out;
    o.f.si = bus.Signed_imm_24_out; o.f.dest = bus.Dest_out; o.f.sr = bus.SR_out;
    o.f.valid = bus.valid_out;
`ifdef FORWARDING_EN
    o.f.src1 = bus.src1_out; o.f.src2 = bus.src2_out;
`endif
    o.err = bus.err_out;
    return o;
  endfunction

  function automatic in_t rand_in();
    in_t i;
    i.wb = 1'($urandom); i.mr = 1'($urandom); i.mw = 1'($urandom);
    i.b  = 1'($urandom); i.s  = 1'($urandom); i.cmd = 4'($urandom);
    i.pc = $urandom; i.rn = $urandom; i.rm = $urandom; i.imm = 1'($urandom);
    i.sh = 12'($urandom); i.si = 24'($urandom); i.dest = 4'($urandom);
    i.sr = 4'($urandom); i.valid = ($urandom_range(0, 3) != 0);
`ifdef FORWARDING_EN
    i.src1 = 4'($urandom); i.src2 = 4'($urandom);
`endif
    return i;
  endfunction

  task automatic drive(input in_t i, input bit fl, input bit fr);
    bus.flush = fl; bus.freeze = fr;
    bus.WB_EN_in = i.wb; bus.MEM_R_in = i.mr; bus.MEM_W_in = i.mw;
    bus.B_in = i.b; bus.S_in = i.s; bus.EXE_CMD_in = i.cmd;
    bus.PC_in = i.pc; bus.Val_Rn_in = i.rn; bus.Val_Rm_in = i.rm;
    bus.imm_in = i.imm; bus.Shift_operand_in = i.sh;
    bus.Signed_imm_24_in = i.si; bus.Dest_in = i.dest; bus.SR_in = i.sr;
    bus.valid_in = i.valid;
`ifdef FORWARDING_EN
    bus.src1_in = i.src1; bus.src2_in = i.src2;
`endif
  endtask

  // Drive one cycle, advance the reference, settle past the edge.
  task automatic apply(input in_t i, input bit fl, input bit fr);
    drive(i, fl, fr);
    @(posedge clk);
    exp_st = model(exp_st, i, fl, fr);
    #1;
  endtask

  // Mid-cycle asynchronous reset, released away from the edge.
  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1 exp_st = '0;
    n_cmp++;
    if (sample() !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL async_reset: got %h want 0", sample());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_t ones;
    ones = '1;
    drive(ones, 1'b0, 1'b0);
    @(posedge clk);
    pulse_reset();
    apply(ones, 1'b0, 1'b0);
    n_cmp++;
    if (sample() !== exp_st) begin
      n_bad++;
      $display("FAIL reset_release_load: got %h want %h", sample(), exp_st);
    end
  endtask

  task automatic test_normal_load();
    in_t i;
    pulse_reset();
    i = '0;
    i.cmd = 4'b0010; i.wb = 1'b1; i.rn = 32'd5; i.rm = 32'd7;
    i.dest = 4'd3; i.valid = 1'b1;
    apply(i, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.EXE_CMD_out, bus.WB_EN_out, bus.Val_Rn_out, bus.Val_Rm_out, bus.Dest_out, bus.valid_out}
        !== {4'b0010, 1'b1, 32'd5, 32'd7, 4'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL add_load: got cmd=%b wb=%b rn=%0d rm=%0d dest=%0d v=%b", bus.EXE_CMD_out,
               bus.WB_EN_out, bus.Val_Rn_out, bus.Val_Rm_out, bus.Dest_out, bus.valid_out);
    end
    n_cmp++;
    if (sample() !== exp_st) begin
      n_bad++;
      $display("FAIL add_load_full: got %h want %h", sample(), exp_st);
    end
  endtask

  task automatic test_freeze();
    in_t i;
    i = rand_in();
    i.pc = 32'h10;
    apply(i, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      i.pc = 32'h10 + 32'(4 * k);
      apply(i, 1'b0, 1'b1);
      n_cmp++;
      if (bus.PC_out !== 32'h10 || sample() !== exp_st) begin
        n_bad++;
        $display("FAIL freeze_hold: got pc=%h want pc=10 (cycle %0d)", bus.PC_out, k);
      end
    end
    apply(i, 1'b0, 1'b0);
    n_cmp++;
    if (bus.PC_out !== 32'h1C) begin
      n_bad++;
      $display("FAIL freeze_release: got pc=%h want 1c", bus.PC_out);
    end
  endtask

  task automatic test_flush_precedence();
    in_t i;
    apply(rand_in(), 1'b0, 1'b0);
    i = rand_in();
    i.mw = 1'b1; i.mr = 1'b0; i.valid = 1'b1;
    apply(i, 1'b1, 1'b1);
    n_cmp++;
    if ({bus.MEM_W_out, bus.valid_out, bus.PC_out, bus.Val_Rn_out, bus.Val_Rm_out,
         bus.Dest_out, bus.Signed_imm_24_out, bus.Shift_operand_out} !== '0) begin
      n_bad++;
      $display("FAIL flush_bubble: got %h want 0 (mw=%b v=%b)", sample(), bus.MEM_W_out, bus.valid_out);
    end
    n_cmp++;
    if (sample() !== exp_st) begin
      n_bad++;
      $display("FAIL flush_full: got %h want %h", sample(), exp_st);
    end
  endtask

  task automatic test_sanitise();
    in_t i;
    pulse_reset();
    i = rand_in();
    i.valid = 1'b1; i.b = 1'b1; i.s = 1'b1;
    apply(i, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.B_out, bus.S_out} !== 2'b10) begin
      n_bad++;
      $display("FAIL branch_no_s: got b=%b s=%b want b=1 s=0", bus.B_out, bus.S_out);
    end
    i = rand_in();
    i.valid = 1'b1; i.mr = 1'b1; i.mw = 1'b1;
    apply(i, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.MEM_R_out, bus.MEM_W_out, bus.err_out} !== 3'b101) begin
      n_bad++;
      $display("FAIL rw_illegal: got r=%b w=%b err=%b want 1 0 1", bus.MEM_R_out, bus.MEM_W_out, bus.err_out);
    end
    for (int k = 0; k < 6; k++) begin
      i = rand_in();
      i.mw = i.mw & ~i.mr;
      apply(i, (k == 2), (k == 4));
      n_cmp++;
      if (bus.err_out !== 1'b1 || sample() !== exp_st) begin
        n_bad++;
        $display("FAIL err_sticky: got err=%b full %h want %h", bus.err_out, sample(), exp_st);
      end
    end
    pulse_reset();
    i = rand_in();
    i.valid = 1'b0; i.mr = 1'b1; i.mw = 1'b1;
    apply(i, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.err_out, bus.WB_EN_out, bus.MEM_R_out, bus.MEM_W_out, bus.B_out, bus.S_out} !== 6'b0
        || bus.PC_out !== i.pc) begin
      n_bad++;
      $display("FAIL invalid_load: got %h want %h", sample(), exp_st);
    end
  endtask

  task automatic test_random();
    in_t i;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 59) == 0) pulse_reset();
      i = rand_in();
      apply(i, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      n_cmp++;
      if (sample() !== exp_st) begin
        n_bad++;
        $display("FAIL random_%0d: got %h want %h", k, sample(), exp_st);
      end
    end
  endtask

`ifdef FORWARDING_EN
  task automatic test_forwarding();
    in_t i;
    i = rand_in();
    i.src1 = 4'd2; i.src2 = 4'd9;
    apply(i, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.src1_out, bus.src2_out} !== {4'd2, 4'd9}) begin
      n_bad++;
      $display("FAIL fwd_load: got %0d %0d want 2 9", bus.src1_out, bus.src2_out);
    end
    apply(rand_in(), 1'b1, 1'b0);
    n_cmp++;
    if ({bus.src1_out, bus.src2_out} !== 8'd0) begin
      n_bad++;
      $display("FAIL fwd_flush: got %0d %0d want 0 0", bus.src1_out, bus.src2_out);
    end
  endtask
`endif

  initial begin
    exp_st = '0;
    test_reset();
    test_normal_load();
    test_freeze();
    test_flush_precedence();
    test_sanitise();
`ifdef FORWARDING_EN
    test_forwarding();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
